// File: rtl/rfphoenix_dcache_wr_arbiter_if.sv
// rfphoenix_dcache_wr_arbiter_if
//
// Purpose: bundles every request, grant and write-port signal of the
// data-cache write arbiter, so the arbiter and its environment share one
// connection.
//
// Signal summary:
//   fill_*    line refill beats from the bus interface (fill_gnt, fill_err back)
//   st_*      store-hit updates from the memory stage (st_gnt back)
//   inv_*     line invalidations (inv_gnt back)
//   wr_*      sequenced dcache RAM write port driven by the arbiter
//
// Modports:
//   slave     the arbiter: takes requests, returns grants, drives the RAM port
//   master    the requesters/RAM side: drives requests, observes the rest
interface rfphoenix_dcache_wr_arbiter_if #(
  parameter int ABITS = 32,
  parameter int DBITS = 128
);
  localparam int SBITS = DBITS / 8;

  logic             fill_req;
  logic [ABITS-1:0] fill_adr;
  logic [DBITS-1:0] fill_dat;
  logic             fill_last;
  logic             fill_gnt;
  logic             fill_err;

  logic             st_req;
  logic [ABITS-1:0] st_adr;
  logic [DBITS-1:0] st_dat;
  logic [SBITS-1:0] st_sel;
  logic             st_hit;
  logic             st_cacheable;
  logic             st_gnt;

  logic             inv_req;
  logic [ABITS-1:0] inv_adr;
  logic             inv_gnt;

  logic             wr;
  logic [ABITS-1:0] wr_adr;
  logic [DBITS-1:0] wr_dat;
  logic [SBITS-1:0] wr_sel;
  logic             wr_tag;
  logic             wr_inv;

  modport slave (
    input  fill_req, fill_adr, fill_dat, fill_last,
    output fill_gnt, fill_err,
    input  st_req, st_adr, st_dat, st_sel, st_hit, st_cacheable,
    output st_gnt,
    input  inv_req, inv_adr,
    output inv_gnt,
    output wr, wr_adr, wr_dat, wr_sel, wr_tag, wr_inv
  );

  modport master (
    output fill_req, fill_adr, fill_dat, fill_last,
    input  fill_gnt, fill_err,
    output st_req, st_adr, st_dat, st_sel, st_hit, st_cacheable,
    input  st_gnt,
    output inv_req, inv_adr,
    input  inv_gnt,
    input  wr, wr_adr, wr_dat, wr_sel, wr_tag, wr_inv
  );
endinterface

// File: rtl/rfphoenix_dcache_wr_arbiter.sv
// rfphoenix_dcache_wr_arbiter
//
// Purpose: arbitrates the single data-cache write port between line
// refills, store-hit updates and line invalidations. A refill owns its line
// from the first beat until the closing tag/valid write; stores and
// invalidates to other lines may use the cycles in which no fill beat is
// offered. Grants are combinational, the RAM port is registered (latency 1).
//
// Ports:
//   clk   clock, all logic on the rising edge
//   rst   synchronous active-high reset; forces all grants low while high
//   bus   rfphoenix_dcache_wr_arbiter_if.slave (requests, grants, RAM port)
module rfphoenix_dcache_wr_arbiter #(
  parameter int ABITS  = 32,
  parameter int DBITS  = 128,
  parameter int BEATS  = 4,
  parameter int STARVE = 4
) (
  input logic                          clk,
  input logic                          rst,
  rfphoenix_dcache_wr_arbiter_if.slave bus
);

  localparam int SBITS = DBITS / 8;
  localparam int BOFF  = $clog2(SBITS);
  localparam int LOFF  = $clog2(BEATS * SBITS);
  localparam int LBITS = ABITS - LOFF;
  localparam int CBITS = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WBITS = $clog2(STARVE + 1);

  localparam logic [CBITS-1:0] LAST_BEAT = CBITS'(BEATS - 1);
  localparam logic [WBITS-1:0] WAIT_MAX  = WBITS'(STARVE);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    TAGUPD
  } state_e;

  state_e           state_q, state_d;
  logic [CBITS-1:0] beat_q, beat_d;
  logic [LBITS-1:0] line_q, line_d;
  logic [WBITS-1:0] wait_q, wait_d;

  logic             wr_q, wr_d;
  logic             tag_q, tag_d;
  logic             inv_q, inv_d;
  logic             err_q, err_d;
  logic [ABITS-1:0] adr_q, adr_d;
  logic [DBITS-1:0] dat_q, dat_d;
  logic [SBITS-1:0] sel_q, sel_d;

  logic             st_write;
  logic             st_nowrite;
  logic             st_starved;
  logic             st_other;
  logic             inv_other;
  logic             gnt_fill;
  logic             gnt_st_w;
  logic             gnt_st_nw;
  logic             gnt_inv;
  logic [CBITS-1:0] fill_beat;
  logic             fill_at_end;
  logic [LBITS-1:0] fill_line;

  // Only cacheable hits actually touch the RAM; every other store is just
  // acknowledged so the memory stage can move on.
  assign st_write   = bus.st_req & bus.st_hit & bus.st_cacheable;
  assign st_nowrite = bus.st_req & ~(bus.st_hit & bus.st_cacheable);
  assign st_starved = (wait_q == WAIT_MAX);

  // While a fill owns a line, only requests to other lines may slip in.
  assign st_other  = st_write    & (bus.st_adr[ABITS-1:LOFF]  != line_q);
  assign inv_other = bus.inv_req & (bus.inv_adr[ABITS-1:LOFF] != line_q);

  // The first beat is taken in IDLE, so it always uses beat 0 and the
  // incoming line address; later beats use the latched line and counter.
  assign fill_beat   = (state_q == FILL) ? beat_q : '0;
  assign fill_at_end = (fill_beat == LAST_BEAT);
  assign fill_line   = (state_q == IDLE) ? bus.fill_adr[ABITS-1:LOFF] : line_q;

  // Grant selection. A starved store jumps ahead of inv and a fill start,
  // but never ahead of a beat of a fill already in progress.
  always_comb begin
    gnt_fill = 1'b0;
    gnt_st_w = 1'b0;
    gnt_inv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_write && st_starved) gnt_st_w = 1'b1;
        else if (bus.inv_req)       gnt_inv  = 1'b1;
        else if (bus.fill_req)      gnt_fill = 1'b1;
        else if (st_write)          gnt_st_w = 1'b1;
      end
      FILL: begin
        if (bus.fill_req)                gnt_fill = 1'b1;
        else if (st_other && st_starved) gnt_st_w = 1'b1;
        else if (inv_other)              gnt_inv  = 1'b1;
        else if (st_other)               gnt_st_w = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      gnt_fill = 1'b0;
      gnt_st_w = 1'b0;
      gnt_inv  = 1'b0;
    end
  end

  assign gnt_st_nw = st_nowrite & (state_q != TAGUPD) & ~rst;

  assign bus.fill_gnt = gnt_fill;
  assign bus.st_gnt   = gnt_st_w | gnt_st_nw;
  assign bus.inv_gnt  = gnt_inv;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      tag_q   <= 1'b0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      tag_q   <= tag_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

  // Next state. A beat-count mismatch (early fill_last, or the final beat
  // without fill_last) still writes the beat but drops back to IDLE
  // without the tag write, leaving the line invalid.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    case (state_q)
      IDLE, FILL: begin
        if (gnt_fill) begin
          line_d = fill_line;
          if (bus.fill_last && fill_at_end) begin
            state_d = TAGUPD;
            beat_d  = '0;
          end else if (bus.fill_last || fill_at_end) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            state_d = FILL;
            beat_d  = fill_beat + CBITS'(1);
          end
        end
      end
      TAGUPD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (st_write && !gnt_st_w)
      wait_d = st_starved ? wait_q : wait_q + WBITS'(1);
    else
      wait_d = '0;
  end

  // RAM port for the next cycle. Address/data/select hold their last value
  // when nothing is issued so the RAM bus does not toggle needlessly.
  always_comb begin
    wr_d  = 1'b0;
    tag_d = 1'b0;
    inv_d = 1'b0;
    err_d = 1'b0;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    if (gnt_fill) begin
      wr_d  = 1'b1;
      adr_d = {fill_line, {LOFF{1'b0}}} | (ABITS'(fill_beat) << BOFF);
      dat_d = bus.fill_dat;
      sel_d = '1;
      err_d = bus.fill_last ^ fill_at_end;
    end else if (gnt_st_w) begin
      wr_d  = 1'b1;
      adr_d = bus.st_adr;
      dat_d = bus.st_dat;
      sel_d = bus.st_sel;
    end else if (gnt_inv) begin
      inv_d = 1'b1;
      adr_d = bus.inv_adr;
    end else if (state_q == TAGUPD) begin
      tag_d = 1'b1;
      adr_d = {line_q, {LOFF{1'b0}}};
    end
  end

  assign bus.wr       = wr_q;
  assign bus.wr_tag   = tag_q;
  assign bus.wr_inv   = inv_q;
  assign bus.fill_err = err_q;
  assign bus.wr_adr   = adr_q;
  assign bus.wr_dat   = dat_q;
  assign bus.wr_sel   = sel_q;

endmodule

// File: doc/rfphoenix_dcache_wr_arbiter.md
# rfphoenix_dcache_wr_arbiter

Arbitrates the single data-cache write port between three requesters: line refills from the bus interface, store-hit updates from the memory stage, and line invalidations. A refill locks its line until all beats and the closing tag/valid write complete, while stores and invalidates to other lines may use idle cycles. It sits between the memory-stage state machine and the dcache RAM and replaces per-state write-enable decoding with one sequenced port.

## Interface
- ABITS, 32, address width
- DBITS, 128, data bits per write (one fill beat)
- BEATS, 4, beats per cache line (line = BEATS*DBITS/8 bytes = 64)
- STARVE, 4, store wait cycles before store priority is raised
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- fill_req  in  1  fill beat valid; fill_adr in ABITS line address, sampled on first beat only; fill_dat in DBITS; fill_last in 1
- fill_gnt  out  1  combinational; beat accepted when fill_req&fill_gnt
- fill_err  out  1  registered one-cycle pulse, beat-count error
- st_req  in  1  store request; st_adr in ABITS; st_dat in DBITS; st_sel in DBITS/8 byte enables; st_hit in 1; st_cacheable in 1 (acr[3])
- st_gnt  out  1  combinational; store consumed when st_req&st_gnt
- inv_req  in  1  invalidate; inv_adr in ABITS; inv_gnt out 1 combinational
- wr  out  1  registered data write strobe; wr_adr out ABITS; wr_dat out DBITS; wr_sel out DBITS/8
- wr_tag  out  1  registered tag write + valid set for wr_adr line
- wr_inv  out  1  registered valid clear for wr_adr line

## Operation
- States: IDLE, FILL, TAGUPD. Registers: beat counter (log2 BEATS bits), fill line address, store wait counter (saturating at STARVE).
- Line compare uses adr[ABITS-1:6]; beat index is adr[5:4].
- IDLE priority: store if wait==STARVE, else inv > fill > store. A fill grant latches fill_adr line, writes beat 0, beat counter=1, goes FILL (or TAGUPD if fill_last with BEATS==1).
- FILL: fill beat always wins; wr_adr = {fill line, beat counter, 4'b0}; wr_sel all ones; counter increments. In cycles with fill_req low, inv or store to a different line may be granted (same priority rule); same-line inv/store stalled.
- fill_last when counter==BEATS-1 -> TAGUPD. fill_last at any other count -> beat written, fill_err pulse, no tag write, -> IDLE. Beat BEATS-1 without fill_last -> fill_err, -> IDLE.
- TAGUPD: one cycle, wr_tag=1, wr_adr=line; no grants; -> IDLE.
- Store with !st_hit or !st_cacheable: st_gnt=1 in any state except TAGUPD, regardless of priority; no write issued (wr stays 0).
- Stall-free grant of a writing store: wr=1, wr_adr=st_adr, wr_dat=st_dat, wr_sel=st_sel.
- Inv grant: wr_inv=1, wr_adr=inv_adr; wr=0.
- Store wait counter increments each cycle a writing store request is pending and not granted, clears on grant or st_req low.
- At most one grant per cycle among writing requesters; wr, wr_tag, wr_inv mutually exclusive.

## Timing
- Grants combinational from registered state and current requests; port outputs registered, valid the cycle after grant (latency 1).
- Requester advances its request the cycle after req&gnt; one fill beat per cycle sustained.
- Full fill of BEATS beats: BEATS grant cycles plus 1 TAGUPD cycle; wr_tag appears 2 cycles after last beat grant.
- Reset values: state IDLE, counters 0, wr/wr_tag/wr_inv/fill_err 0, wr_adr/wr_dat/wr_sel 0. Reset mid-fill abandons the fill: no wr_tag, gnts 0 during rst.
- Simultaneous inv and fill start in IDLE: inv granted, fill granted next cycle.

## Test plan
- Fill 4 beats back-to-back line 0x1000 -> wr 4 cycles at 0x1000/10/20/30, then wr_tag at 0x1000, fill_err 0.
- Store hit cacheable 0x2004, sel 0x00F0 during fill gap -> st_gnt same cycle, wr next cycle at 0x2004; store to 0x1010 mid-fill stalls until after wr_tag.
- Store with st_cacheable=0 during TAGUPD -> no gnt; next cycle st_gnt=1, wr never asserted.
- Continuous inv_req plus store pending -> store granted on 5th waiting cycle (STARVE=4).
- fill_last on beat 2 -> 3 writes, fill_err pulse, no wr_tag, state IDLE.
- rst asserted after beat 1 -> all outputs 0 next cycle, no wr_tag; new fill starts at beat 0.
